// File: rtl/eth_frame_pkg.sv
// Shared definitions for the Ethernet test-frame generator.
//   HDR_BYTES / MIN_PAYLOAD / MAX_PAYLOAD : frame geometry constants
//   gen_state_t                           : generator FSM states
//   keep_mask()                           : per-beat valid-byte mask
//   frame_total()                         : clamped payload length plus header
package eth_frame_pkg;

  localparam int unsigned HDR_BYTES   = 14;
  localparam int unsigned MIN_PAYLOAD = 46;
  localparam int unsigned MAX_PAYLOAD = 1500;

  typedef enum logic [1:0] {IDLE, SEND, GAP} gen_state_t;

  // Lane j of beat n is valid while its frame byte index 4n+j is below total.
  function automatic logic [3:0] keep_mask(input logic [10:0] total, input logic [8:0] beat);
    logic [10:0] base;
    logic [3:0]  keep;
    base = {beat, 2'b00};
    keep = '0;
    for (int j = 0; j < 4; j++) begin
      keep[j] = (base + 11'(j)) < total;
    end
    return keep;
  endfunction

  // Total frame bytes after clamping the payload into the legal Ethernet range.
  function automatic logic [10:0] frame_total(input logic [15:0] len);
    logic [10:0] pay;
    if (len < 16'(MIN_PAYLOAD)) begin
      pay = 11'(MIN_PAYLOAD);
    end else if (len > 16'(MAX_PAYLOAD)) begin
      pay = 11'(MAX_PAYLOAD);
    end else begin
      pay = len[10:0];
    end
    return pay + 11'(HDR_BYTES);
  endfunction

endpackage

// File: rtl/frame_beat_builder.sv
// Combinational beat former: maps a beat index and frame length onto the 32-bit
// AXI-Stream lanes (byte j of the beat in tdata[8j+7:8j]).
//   beat_i  : beat index within the frame
//   total_i : total frame bytes (header + clamped payload)
//   seq_i   : sequence number for payload bytes 0-3 (only with SEQ_NUM_EN)
//   tdata_o / tkeep_o / tlast_o : beat contents
// Optional feature macro: SEQ_NUM_EN.
module frame_beat_builder
  import eth_frame_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic [8:0]  beat_i,
  input  logic [10:0] total_i,
`ifdef SEQ_NUM_EN
  input  logic [31:0] seq_i,
`endif
  output logic [31:0] tdata_o,
  output logic [3:0]  tkeep_o,
  output logic        tlast_o
);

  logic [10:0] base;
  assign base = {beat_i, 2'b00};

  // Header addresses go out MSB first, so byte idx selects bits from the top down.
  function automatic logic [7:0] frame_byte(input logic [10:0] idx);
    logic [7:0] b;
    if (idx < 11'd6) begin
      b = 8'(DST_MAC >> {3'd5 - idx[2:0], 3'b000});
    end else if (idx < 11'd12) begin
      b = 8'(SRC_MAC >> {3'(4'd11 - idx[3:0]), 3'b000});
    end else if (idx == 11'd12) begin
      b = ETHERTYPE[15:8];
    end else if (idx == 11'd13) begin
      b = ETHERTYPE[7:0];
    end else begin
      b = 8'(idx - 11'(HDR_BYTES));
    end
    return b;
  endfunction

  always_comb begin
    tdata_o = '0;
    for (int j = 0; j < 4; j++) begin
      tdata_o[8*j +: 8] = frame_byte(base + 11'(j));
`ifdef SEQ_NUM_EN
      // Payload bytes 0-3 carry the sequence number, MSB first.
      if ((base + 11'(j)) >= 11'(HDR_BYTES) && (base + 11'(j)) < 11'(HDR_BYTES + 4)) begin
        tdata_o[8*j +: 8] =
          8'(seq_i >> {2'd3 - 2'(base + 11'(j) - 11'(HDR_BYTES)), 3'b000});
      end
`endif
    end
  end

  assign tkeep_o = keep_mask(total_i, beat_i);
  assign tlast_o = (base + 11'd4) >= total_i;

endmodule

// File: rtl/axis_frame_gen.sv
// Ethernet test-traffic source: emits complete frames (DA, SA, EtherType, payload)
// as a 32-bit AXI-Stream master with tready backpressure.
//   clk, reset          : single clock, synchronous active-high reset
//   start, payload_len  : frame request (sampled in IDLE) and payload byte count
//   busy, done          : activity flag and end-of-frame pulse
//   frame_count         : frames completed since reset
//   m00_axis_*          : AXI-Stream master (tdata/tkeep/tvalid/tready/tlast)
// Optional feature macro: SEQ_NUM_EN (sequence number in payload bytes 0-3).
module axis_frame_gen
  import eth_frame_pkg::*;
#(
  parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC    = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter int unsigned IFG_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] payload_len,
  output logic        busy,
  output logic        done,
  output logic [31:0] frame_count,
  output logic [31:0] m00_axis_tdata,
  output logic [3:0]  m00_axis_tkeep,
  output logic        m00_axis_tvalid,
  input  logic        m00_axis_tready,
  output logic        m00_axis_tlast
);

  gen_state_t  state_q;
  logic [10:0] total_q, total_d;
  logic [8:0]  beat_q, beat_d;
  logic [15:0] gap_q;
  logic        busy_q, done_q, tvalid_q, tlast_q;
  logic [31:0] tdata_q, fc_q;
  logic [3:0]  tkeep_q;
  logic [31:0] bld_tdata;
  logic [3:0]  bld_tkeep;
  logic        bld_tlast;
`ifdef SEQ_NUM_EN
  logic [31:0] seq_q, seq_d;
`endif

  // The builder is fed the beat about to be registered, so beat 0 is ready on the
  // cycle right after start and later beats follow each handshake without a bubble.
  always_comb begin
    if (state_q == IDLE) begin
      total_d = frame_total(payload_len);
      beat_d  = '0;
    end else begin
      total_d = total_q;
      beat_d  = beat_q + 9'd1;
    end
  end

`ifdef SEQ_NUM_EN
  assign seq_d = (state_q == IDLE) ? fc_q : seq_q;
`endif

  frame_beat_builder #(
    .DST_MAC   (DST_MAC),
    .SRC_MAC   (SRC_MAC),
    .ETHERTYPE (ETHERTYPE)
  ) u_builder (
    .beat_i  (beat_d),
    .total_i (total_d),
`ifdef SEQ_NUM_EN
    .seq_i   (seq_d),
`endif
    .tdata_o (bld_tdata),
    .tkeep_o (bld_tkeep),
    .tlast_o (bld_tlast)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      total_q  <= '0;
      beat_q   <= '0;
      gap_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      fc_q     <= '0;
`ifdef SEQ_NUM_EN
      seq_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= SEND;
            busy_q   <= 1'b1;
            total_q  <= total_d;
            beat_q   <= beat_d;
            tvalid_q <= 1'b1;
            tdata_q  <= bld_tdata;
            tkeep_q  <= bld_tkeep;
            tlast_q  <= bld_tlast;
`ifdef SEQ_NUM_EN
            seq_q    <= seq_d;
`endif
          end
        end
        SEND: begin
          // tvalid is always high here; a stall simply holds every output register.
          if (m00_axis_tready) begin
            if (tlast_q) begin
              state_q  <= GAP;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              tdata_q  <= '0;
              tkeep_q  <= '0;
              done_q   <= 1'b1;
              fc_q     <= fc_q + 32'd1;
              gap_q    <= 16'(IFG_CYCLES);
              // With no gap, busy falls together with done.
              busy_q   <= (IFG_CYCLES != 0);
            end else begin
              beat_q   <= beat_d;
              tdata_q  <= bld_tdata;
              tkeep_q  <= bld_tkeep;
              tlast_q  <= bld_tlast;
            end
          end
        end
        GAP: begin
          // busy drops after the gap count expires; IDLE follows one cycle later so a
          // start seen while busy falls is never accepted.
          if (!busy_q) begin
            state_q <= IDLE;
          end else if (gap_q == '0) begin
            busy_q <= 1'b0;
          end else begin
            gap_q <= gap_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign frame_count     = fc_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tkeep  = tkeep_q;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed self-checking bench for axis_frame_gen (default parameters, IFG_CYCLES=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_axis_frame_gen;

  logic        clk = 1'b0;
  logic        reset, start, tready;
  logic [15:0] payload_len;
  logic        busy, done, tvalid, tlast;
  logic [31:0] frame_count, tdata;
  logic [3:0]  tkeep;

  always #5 clk = ~clk;

  axis_frame_gen dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .payload_len     (payload_len),
    .busy            (busy),
    .done            (done),
    .frame_count     (frame_count),
    .m00_axis_tdata  (tdata),
    .m00_axis_tkeep  (tkeep),
    .m00_axis_tvalid (tvalid),
    .m00_axis_tready (tready),
    .m00_axis_tlast  (tlast)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rx_q[$];
  int          n_beats, stall_viol, keep_viol, bubble;
  bit          got_last;
  logic [3:0]  last_keep;
  logic [31:0] first_data, fc_after;
  logic        done_after, valid_after;
  int          exp_fc;

  // Reference byte map: DA all FF, SA 02:00:00:00:00:01, EtherType 88B5, payload k.
  function automatic logic [7:0] exp_byte(input int idx);
`ifdef SEQ_NUM_EN
    logic [31:0] s;
    s = exp_fc;
    if (idx >= 14 && idx < 18) return s[8*(17-idx) +: 8];
`endif
    if (idx < 6) return 8'hFF;
    if (idx == 6) return 8'h02;
    if (idx < 11) return 8'h00;
    if (idx == 11) return 8'h01;
    if (idx == 12) return 8'h88;
    if (idx == 13) return 8'hB5;
    return 8'(idx - 14);
  endfunction

  function automatic int stream_errs(input int total);
    int m = 0;
    if (rx_q.size() != total) m = 100000;
    for (int i = 0; i < rx_q.size() && i < total; i++) begin
      if (rx_q[i] !== exp_byte(i)) m++;
    end
    return m;
  endfunction

  task automatic kick(input logic [15:0] len);
    start = 1'b1;
    payload_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Gathers one frame's handshaked bytes; ends on the cycle after the tlast handshake.
  task automatic collect(input bit rnd, input bit hold_start);
    logic [31:0] pd;
    logic [3:0]  pk;
    logic        pl;
    bit          pstall, rdy;
    rx_q.delete();
    n_beats = 0; stall_viol = 0; keep_viol = 0; bubble = 0; got_last = 1'b0;
    last_keep = '0; first_data = '0; pstall = 1'b0; pd = '0; pk = '0; pl = 1'b0;
    for (int cyc = 0; cyc < 6000 && !got_last; cyc++) begin
      start = hold_start;
      if (!tvalid) begin
        bubble++;
      end else begin
        if (pstall && (tdata !== pd || tkeep !== pk || tlast !== pl)) stall_viol++;
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        tready = rdy;
        if (rdy) begin
          if (n_beats == 0) first_data = tdata;
          for (int j = 0; j < 4; j++) if (tkeep[j]) rx_q.push_back(tdata[8*j +: 8]);
          if (!tlast && tkeep !== 4'hF) keep_viol++;
          n_beats++;
          if (tlast) begin
            got_last = 1'b1;
            last_keep = tkeep;
          end
        end
        pstall = !rdy; pd = tdata; pk = tkeep; pl = tlast;
      end
      @(negedge clk);
    end
    tready = 1'b1;
    done_after = done; valid_after = tvalid; fc_after = frame_count;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy) begin errors++; $display("FAIL wait_idle busy=%0b want 0", busy); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; payload_len = '0; tready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", tvalid); end
    checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", tlast); end
    checks++; if (tkeep !== 4'h0) begin errors++; $display("FAIL rst_tkeep got %h want 0", tkeep); end
    checks++; if (tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata got %h want 0", tdata); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %b%b want 00", busy, done); end
    checks++; if (frame_count !== 32'h0) begin errors++; $display("FAIL rst_fc got %0d want 0", frame_count); end
    reset = 1'b0;
    exp_fc = 0;
    @(negedge clk);
  endtask

  task automatic test_min_frame();
    int m;
    kick(16'd46);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL min_busy got %b want 1", busy); end
    collect(1'b0, 1'b0);
    m = stream_errs(60);
    exp_fc++;
    checks++; if (n_beats != 15 || !got_last) begin errors++; $display("FAIL min_beats got %0d want 15", n_beats); end
    checks++; if (bubble != 0) begin errors++; $display("FAIL min_bubbles got %0d want 0", bubble); end
    checks++; if (first_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL min_beat0 got %h want ffffffff", first_data); end
    checks++; if (last_keep !== 4'b1111) begin errors++; $display("FAIL min_last_keep got %b want 1111", last_keep); end
    checks++; if (m != 0) begin errors++; $display("FAIL min_stream bad=%0d want 0", m); end
    checks++; if (done_after !== 1'b1 || valid_after !== 1'b0) begin errors++; $display("FAIL min_done got done=%b tvalid=%b want 1 0", done_after, valid_after); end
    checks++; if (fc_after !== 32'd1) begin errors++; $display("FAIL min_fc got %0d want 1", fc_after); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL min_done_pulse got %b want 0", done); end
    wait_idle();
  endtask

  task automatic test_lengths();
    int m;
    kick(16'd47);
    collect(1'b0, 1'b0);
    m = stream_errs(61);
    exp_fc++;
    checks++; if (n_beats != 16) begin errors++; $display("FAIL len47_beats got %0d want 16", n_beats); end
    checks++; if (last_keep !== 4'b0001) begin errors++; $display("FAIL len47_keep got %b want 0001", last_keep); end
    // Final byte is payload byte 46.
    checks++; if (rx_q.size() == 0 || rx_q[rx_q.size()-1] !== 8'h2E) begin errors++; $display("FAIL len47_lastbyte want 2e"); end
    checks++; if (m != 0 || keep_viol != 0) begin errors++; $display("FAIL len47_stream bad=%0d keep=%0d want 0", m, keep_viol); end
    wait_idle();
    kick(16'd1500);
    collect(1'b0, 1'b0);
    m = stream_errs(1514);
    exp_fc++;
    checks++; if (n_beats != 379) begin errors++; $display("FAIL len1500_beats got %0d want 379", n_beats); end
    checks++; if (last_keep !== 4'b0011) begin errors++; $display("FAIL len1500_keep got %b want 0011", last_keep); end
    checks++; if (m != 0 || keep_viol != 0) begin errors++; $display("FAIL len1500_stream bad=%0d keep=%0d want 0", m, keep_viol); end
    wait_idle();
  endtask

  task automatic test_clamp();
    int m;
    kick(16'd10);
    collect(1'b0, 1'b0);
    m = stream_errs(60);
    exp_fc++;
    checks++; if (n_beats != 15 || m != 0) begin errors++; $display("FAIL clamp_lo beats=%0d bad=%0d want 15 0", n_beats, m); end
    wait_idle();
    kick(16'd4000);
    collect(1'b0, 1'b0);
    m = stream_errs(1514);
    exp_fc++;
    checks++; if (n_beats != 379 || m != 0) begin errors++; $display("FAIL clamp_hi beats=%0d bad=%0d want 379 0", n_beats, m); end
    checks++; if (fc_after !== 32'(exp_fc)) begin errors++; $display("FAIL clamp_fc got %0d want %0d", fc_after, exp_fc); end
    wait_idle();
  endtask

  task automatic test_backpressure();
    int m;
    kick(16'd49);
    collect(1'b1, 1'b0);
    m = stream_errs(63);
    exp_fc++;
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_hold changes=%0d want 0", stall_viol); end
    checks++; if (bubble != 0) begin errors++; $display("FAIL bp_tvalid_drop got %0d want 0", bubble); end
    checks++; if (n_beats != 16 || last_keep !== 4'b0111) begin errors++; $display("FAIL bp_beats got %0d/%b want 16/0111", n_beats, last_keep); end
    checks++; if (m != 0) begin errors++; $display("FAIL bp_stream bad=%0d want 0", m); end
    wait_idle();
  endtask

  task automatic test_ignore_start_ifg();
    int k = 0;
    kick(16'd46);
    payload_len = 16'd200;
    collect(1'b0, 1'b1);
    exp_fc++;
    checks++; if (n_beats != 15) begin errors++; $display("FAIL ign_beats got %0d want 15", n_beats); end
    checks++; if (fc_after !== 32'(exp_fc)) begin errors++; $display("FAIL ign_fc got %0d want %0d", fc_after, exp_fc); end
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k != 5) begin errors++; $display("FAIL ifg_busy_fall got %0d want 5", k); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tvalid !== 1'b0) begin errors++; $display("FAIL ign_fall_start busy=%b tvalid=%b want 0 0", busy, tvalid); end
    start = 1'b0;
    payload_len = 16'd46;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int m;
    tready = 1'b1;
    kick(16'd46);
    repeat (7) @(negedge clk);
    checks++; if (tvalid !== 1'b1 || tlast !== 1'b0) begin errors++; $display("FAIL mid_pre tvalid=%b tlast=%b want 1 0", tvalid, tlast); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_fc = 0;
    checks++; if (tvalid !== 1'b0 || tlast !== 1'b0) begin errors++; $display("FAIL mid_rst tvalid=%b tlast=%b want 0 0", tvalid, tlast); end
    checks++; if (frame_count !== 32'h0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst fc=%0d busy=%b want 0 0", frame_count, busy); end
    @(negedge clk);
    kick(16'd46);
    collect(1'b0, 1'b0);
    m = stream_errs(60);
    exp_fc++;
    checks++; if (m != 0 || n_beats != 15) begin errors++; $display("FAIL mid_fresh bad=%0d beats=%0d want 0 15", m, n_beats); end
    checks++; if (fc_after !== 32'd1) begin errors++; $display("FAIL mid_fc got %0d want 1", fc_after); end
    wait_idle();
  endtask

  task automatic test_seq();
    logic [31:0] field, want;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_fc = 0;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      kick(16'd46);
      collect(1'b0, 1'b0);
      exp_fc++;
      wait_idle();
    end
    field = {rx_q[14], rx_q[15], rx_q[16], rx_q[17]};
`ifdef SEQ_NUM_EN
    want = 32'h0000_0002;
`else
    want = 32'h0001_0203;
`endif
    checks++; if (field !== want) begin errors++; $display("FAIL seq_field got %h want %h", field, want); end
  endtask

  initial begin
    test_reset();
    test_min_frame();
    test_lengths();
    test_clamp();
    test_backpressure();
    test_ignore_start_ifg();
    test_reset_mid();
    test_seq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
